// File: rtl/dense_argmax_if.sv
// Stream bus for dense_argmax. The inference beats come in, and the winning class and its value go out.
// The master side is the upstream neuron producer together with the decision consumer.
// The slave side is the argmax block itself.
interface dense_argmax_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [IDX_WIDTH-1:0]  class_o;
    logic [DATA_WIDTH-1:0] max_o;
    logic                  valid_o;
    logic                  ready_i;

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, class_o, max_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, class_o, max_o, valid_o
    );
endinterface

// File: rtl/dense_argmax.sv
// Final classification stage. It scans NUM_CLASSES float32 neuron results, one per
// accepted beat, and keeps the running maximum and its index. It then holds the
// winner on a valid/ready output until the consumer accepts it.
module dense_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    dense_argmax_if.slave    bus
);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [DATA_WIDTH-1:0] QNAN     = 32'h7FC0_0000;
    localparam logic [DATA_WIDTH-1:0] NEG_ZERO = 32'h8000_0000;
    localparam logic [DATA_WIDTH-1:0] SIGN_BIT = 32'h8000_0000;

    typedef enum logic [0:0] {S_COLLECT, S_OUTPUT} state_t;

    state_t                r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_cnt;
    logic [IDX_WIDTH-1:0]  r_class;
    logic [DATA_WIDTH-1:0] r_max;
    logic                  r_valid;
    logic                  r_best_seen;

    logic                  w_accept, w_last, w_nan, w_upd, w_out_hs;
    logic [DATA_WIDTH-1:0] w_key, w_best_key;

    // Turn a float into an unsigned key that sorts the same way as the float.
    // -0 is folded onto +0 first, so the two zeros tie.
    function automatic logic [DATA_WIDTH-1:0] f_key(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] v;
        v = (x == NEG_ZERO) ? '0 : x;
        return v[DATA_WIDTH-1] ? ~v : (v | SIGN_BIT);
    endfunction

    assign w_accept   = bus.valid_i & (r_state == S_COLLECT);
    assign w_last     = w_accept & (r_cnt == LAST_IDX);
    assign w_out_hs   = r_valid & bus.ready_i;
    assign w_nan      = (&bus.data_i[30:23]) & (|bus.data_i[22:0]);
    assign w_key      = f_key(bus.data_i);
    // The best key is derived from the stored max rather than kept in its own register.
    assign w_best_key = f_key(r_max);
    // Strict greater-than: on a tie the earlier (lower) index is kept.
    assign w_upd      = w_accept & ~w_nan & (~r_best_seen | (w_key > w_best_key));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_COLLECT;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: collect a full frame, then hold the result until it is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_last)      w_state_nxt = S_OUTPUT;
            S_OUTPUT:  if (bus.ready_i) w_state_nxt = S_COLLECT;
            default:                    w_state_nxt = S_COLLECT;
        endcase
    end

    // Beat counter, running max/index, and output valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_class     <= '0;
            r_max       <= '0;
            r_valid     <= 1'b0;
            r_best_seen <= 1'b0;
        end else begin
            if (w_accept)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_upd) begin
                r_max       <= bus.data_i;
                r_class     <= r_cnt;
                r_best_seen <= 1'b1;
            end else if (w_last && !r_best_seen) begin
                // The whole frame was NaN, so report a quiet NaN at index 0.
                r_max   <= QNAN;
                r_class <= '0;
            end
            if (w_last) begin
                r_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_valid     <= 1'b0;
                r_best_seen <= 1'b0;
            end
        end
    end

    assign bus.ready_o = (r_state == S_COLLECT);
    assign bus.valid_o = r_valid;
    assign bus.class_o = r_class;
    assign bus.max_o   = r_max;
endmodule
